// File: rtl/plab4_net_router_output_ctrl_if.sv
// Handshake bundle between a ring-router output ctrl and its neighbours.
// master = upstream reqs plus downstream rdy/credits; slave = the output ctrl.
interface plab4_net_router_output_ctrl_if #(
    parameter int p_num_free_nbits = 2
);
    logic [2:0]                  reqs;
    logic [2:0]                  grants;
    logic                        out_val;
    logic                        out_rdy;
    logic                        credit_return;
    logic [p_num_free_nbits-1:0] num_free;

    modport master (
        output reqs,
        output out_rdy,
        output credit_return,
        input  grants,
        input  out_val,
        input  num_free
    );

    modport slave (
        input  reqs,
        input  out_rdy,
        input  credit_return,
        output grants,
        output out_val,
        output num_free
    );
endinterface

// File: rtl/plab4_net_router_output_ctrl.sv
// Ring-router output ctrl: round-robin arbiter plus downstream credit counter.
// Define PLAB4_NET_ROUTER_OUTPUT_CTRL_STATS_EN to add the stall_count output.
module plab4_net_router_output_ctrl #(
    parameter int p_num_entries    = 2,
    parameter int p_num_free_nbits = 2,
    parameter int p_use_credits    = 1
) (
    input  logic clk,
    input  logic reset,
    plab4_net_router_output_ctrl_if.slave port
`ifdef PLAB4_NET_ROUTER_OUTPUT_CTRL_STATS_EN
    ,
    output logic [15:0] stall_count
`endif
);

    localparam int N = p_num_free_nbits;
    localparam logic [N-1:0] CredInit = N'(p_num_entries);
    localparam logic [N-1:0] CredOne  = N'(1);

    logic [1:0]   ptr_q;
    logic [1:0]   ptr_d;
    logic [N-1:0] credits_q;
    logic [N-1:0] credits_d;
    logic [1:0]   win;
    logic         found;
    logic         can_send;
    logic         out_val;
    logic         fire;

    // Rotating search starting at ptr; first requester wins.
    always_comb begin
        int k;
        found = 1'b0;
        win   = 2'd0;
        for (int i = 0; i < 3; i++) begin
            k = int'(ptr_q) + i;
            if (k >= 3) k = k - 3;
            if (!found && port.reqs[k]) begin
                found = 1'b1;
                win   = 2'(k);
            end
        end
    end

    always_comb begin
        can_send = (credits_q != '0) || (p_use_credits == 0);
        out_val  = !reset && found && can_send;
        fire     = out_val && port.out_rdy;
    end

    assign port.out_val  = out_val;
    assign port.grants   = fire ? (3'b001 << win) : 3'b000;
    assign port.num_free = credits_q;

    always_comb begin
        ptr_d = ptr_q;
        if (fire) ptr_d = (win == 2'd2) ? 2'd0 : win + 2'd1;
    end

    // A send and a return in the same cycle cancel out.
    always_comb begin
        credits_d = credits_q;
        if (p_use_credits != 0) begin
            unique case (1'b1)
                fire && !port.credit_return:
                    credits_d = credits_q - CredOne;
                !fire && port.credit_return:
                    credits_d = (credits_q == CredInit) ? credits_q
                                                        : credits_q + CredOne;
                default:
                    credits_d = credits_q;
            endcase
        end else begin
            credits_d = CredInit;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            ptr_q     <= 2'd0;
            credits_q <= CredInit;
        end else begin
            ptr_q     <= ptr_d;
            credits_q <= credits_d;
        end
    end

`ifdef PLAB4_NET_ROUTER_OUTPUT_CTRL_STATS_EN
    logic [15:0] stall_q;
    logic [15:0] stall_d;

    always_comb begin
        stall_d = stall_q;
        if ((|port.reqs) && !fire && (stall_q != 16'hFFFF))
            stall_d = stall_q + 16'd1;
    end

    always_ff @(posedge clk) begin
        if (reset) stall_q <= 16'd0;
        else       stall_q <= stall_d;
    end

    assign stall_count = stall_q;
`endif

endmodule
